// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer, response and size codes, responder FSM
// states, and small decode helpers used by the bus components.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_t;

  // Halfword must sit on an even byte, word on a 4-byte boundary.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_HALF: return lane[0];
      HSIZE_WORD: return (lane != 2'b00);
      default:    return 1'b0;
    endcase
  endfunction

  // Byte lanes touched by a transfer of the given size at the given offset.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lane;
      HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_resp_slave_if.sv
// AHB bus signals seen by the responder, with master and slave views.
interface ahb_resp_slave_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [3:0]  HMASTER;
  logic        SPLIT_EN;
  logic        HREADY_O;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [15:0] HSPLIT;

  modport slave (
    input  HSEL, HREADY, HADDR, HSIZE, HWRITE, HTRANS, HBURST, HWDATA, HMASTER, SPLIT_EN,
    output HREADY_O, HRESP, HRDATA, HSPLIT
  );

  modport master (
    output HSEL, HREADY, HADDR, HSIZE, HWRITE, HTRANS, HBURST, HWDATA, HMASTER, SPLIT_EN,
    input  HREADY_O, HRESP, HRDATA, HSPLIT
  );
endinterface

// File: rtl/ahb_ram_bytes.sv
// Word-wide storage with per-byte write enables and combinational read.
// Contents are deliberately not reset.
module ahb_ram_bytes #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Byte-lane masked write.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_resp_slave.sv
// AHB responder: classifies each accepted address phase as OKAY, ERROR or
// SPLIT, inserts wait states on OKAY, gives two-cycle ERROR/SPLIT responses
// and releases one split master at a time after a fixed delay.
module ahb_resp_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned WAIT_CYC  = 1,
  parameter int unsigned SPLIT_DLY = 8,
  parameter int unsigned NUM_MST   = 16
) (
  input logic             HCLK,
  input logic             HRST,
  ahb_resp_slave_if.slave bus
);
  localparam int unsigned AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam slv_state_t  OK_FIRST  = (WAIT_CYC > 0) ? ST_WAIT : ST_DONE;
  localparam logic [15:0] MST_MASK  = 16'((32'd1 << NUM_MST) - 32'd1);

  slv_state_t    state, state_next;
  hresp_t        resp_cls, resp_q, resp_o;
  logic          ready_o, accept, bad_xfer, id_ok;
  logic [AW-1:0] addr_q;
  logic [1:0]    lane_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic [3:0]    wcnt;
  logic          split_pend;
  logic [7:0]    split_cnt;
  logic [3:0]    split_id;
  logic [15:0]   owed;
  logic [15:0]   hsplit;
  logic [31:0]   ram_rdata, rdata_q;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic          unused_bits;

  // Only take a new address phase while this responder is itself ready.
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & ready_o;

  // Response classification of the address phase on the bus.
  always_comb begin
    bad_xfer = (bus.HADDR[31:2] >= 30'(MEM_DEPTH)) || (bus.HSIZE > HSIZE_WORD) ||
               misaligned(bus.HSIZE, bus.HADDR[1:0]);
    id_ok    = ({28'd0, bus.HMASTER} < NUM_MST);
    resp_cls = HRESP_OKAY;
    if (bad_xfer) begin
      resp_cls = HRESP_ERROR;
    end else if (bus.SPLIT_EN && !split_pend && id_ok && !owed[bus.HMASTER]) begin
      resp_cls = HRESP_SPLIT;
    end
  end

  // State register.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; DONE and ERR2 chain straight into a new transfer.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) state_next = (resp_cls == HRESP_OKAY) ? OK_FIRST : ST_ERR1;
        else        state_next = ST_IDLE;
      end
      ST_WAIT: if (wcnt == WAIT_LAST) state_next = ST_DONE;
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-state handshake outputs.
  always_comb begin
    ready_o = 1'b1;
    resp_o  = HRESP_OKAY;
    unique case (state)
      ST_WAIT: ready_o = 1'b0;
      ST_ERR1: begin
        ready_o = 1'b0;
        resp_o  = resp_q;
      end
      ST_ERR2: resp_o = resp_q;
      default: ;
    endcase
  end

  // Address-phase capture.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      addr_q  <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      resp_q  <= HRESP_OKAY;
    end else if (accept) begin
      addr_q  <= bus.HADDR[AW+1:2];
      lane_q  <= bus.HADDR[1:0];
      size_q  <= bus.HSIZE;
      write_q <= bus.HWRITE;
      resp_q  <= resp_cls;
    end
  end

  // Wait-state counter, restarts on every entry into WAIT.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) wcnt <= '0;
    else      wcnt <= (state == ST_WAIT) ? wcnt + 4'd1 : '0;
  end

  // Split bookkeeping: one pending split, release countdown, and a per-master
  // "owed" bit so the released master's retry is not split again. A release
  // and a same-cycle OKAY from that master leave the bit set.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      split_pend <= 1'b0;
      split_cnt  <= '0;
      split_id   <= '0;
      owed       <= '0;
    end else begin
      if (accept && resp_cls == HRESP_OKAY) owed[bus.HMASTER] <= 1'b0;
      if (split_pend) begin
        if (split_cnt == 8'd0) begin
          split_pend     <= 1'b0;
          owed[split_id] <= 1'b1;
        end else begin
          split_cnt <= split_cnt - 8'd1;
        end
      end
      if (accept && resp_cls == HRESP_SPLIT) begin
        split_pend <= 1'b1;
        split_cnt  <= 8'(SPLIT_DLY);
        split_id   <= bus.HMASTER;
      end
    end
  end

  // Release pulse while the countdown sits at zero.
  always_comb begin
    hsplit = '0;
    if (split_pend && split_cnt == 8'd0) hsplit[split_id] = 1'b1;
    hsplit = hsplit & MST_MASK;
  end

  // Read data holding register, refreshed at the end of each read DONE.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) rdata_q <= '0;
    else if (state == ST_DONE && !write_q) rdata_q <= ram_rdata;
  end

  assign ram_we = (state == ST_DONE) && write_q;
  assign ram_be = byte_lanes(size_q, lane_q);

  ahb_ram_bytes #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
    .clk   (HCLK),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (addr_q),
    .wdata (bus.HWDATA),
    .rdata (ram_rdata)
  );

  assign bus.HREADY_O = ready_o;
  assign bus.HRESP    = resp_o;
  assign bus.HRDATA   = (state == ST_DONE && !write_q) ? ram_rdata : rdata_q;
  assign bus.HSPLIT   = hsplit;

  assign unused_bits = ^{bus.HBURST, bus.HTRANS[0]};
endmodule

// File: doc/ahb_resp_slave.md
AHB_RESP_SLAVE -- requirements
Module: ahb_resp_slave

Interface
REQ-001 Parameter MEM_DEPTH, default 64, sets the number of 32-bit words of internal storage; it SHALL be a power of two.
REQ-002 Parameter WAIT_CYC, default 1, range 0..15, sets the wait states inserted before an OKAY data phase completes.
REQ-003 Parameter SPLIT_DLY, default 8, range 1..255, sets the cycles from the SPLIT response to the HSPLIT release pulse.
REQ-004 Parameter NUM_MST, default 16, range 1..16, sets the number of HSPLIT bits driven; unused upper bits SHALL be 0.
REQ-005 Ports SHALL be as follows:
 HCLK      in   1   clock, all logic on the rising edge
 HRST      in   1   reset, asynchronous, active-high
 HSEL      in   1   slave select
 HREADY    in   1   bus ready (previous transfer complete)
 HADDR     in   32  address
 HSIZE     in   3   transfer size
 HWRITE    in   1   1 = write
 HTRANS    in   2   IDLE/BUSY/NONSEQ/SEQ
 HBURST    in   3   burst type, sampled but not used
 HWDATA    in   32  write data, valid in the data phase
 HMASTER   in   4   current master ID
 SPLIT_EN  in   1   enables SPLIT responses, static per test
 HREADY_O  out  1   slave ready
 HRESP     out  2   OKAY/ERROR/RETRY/SPLIT
 HRDATA    out  32  read data
 HSPLIT    out  16  split release, one bit per master

Function
REQ-006 An address phase SHALL be accepted when HSEL & HREADY & HTRANS[1] are all high at a rising HCLK edge; HADDR, HSIZE, HWRITE and HMASTER SHALL be registered at that edge.
REQ-007 IDLE and BUSY transfers, and unselected cycles, SHALL get a zero-wait OKAY: HREADY_O=1 and HRESP=OKAY.
REQ-008 Response classification, in priority order:
 - ERROR when the word index HADDR[31:2] >= MEM_DEPTH, when HSIZE > 2, or when the address is misaligned (halfword with HADDR[0]=1, word with HADDR[1:0] != 0);
 - SPLIT when SPLIT_EN=1, no split is pending, and the master has not been split since its last release;
 - OKAY otherwise.
REQ-009 FSM states are IDLE, WAIT, DONE, ERR1 and ERR2.
REQ-010 OKAY path, fixed latency of WAIT_CYC+1 cycles:
 - IDLE->WAIT when WAIT_CYC>0, otherwise IDLE->DONE;
 - in WAIT: HREADY_O=0, HRESP=OKAY, a 4-bit counter runs WAIT_CYC cycles, then ->DONE;
 - in DONE: HREADY_O=1, HRESP=OKAY.
REQ-011 Non-OKAY path:
 - IDLE->ERR1: HREADY_O=0, HRESP=response;
 - ERR1->ERR2: HREADY_O=1, HRESP=response;
 - ERR2->IDLE, or directly to a new address phase accepted in ERR2;
 - no storage access occurs on this path.
REQ-012 A new address phase accepted in DONE or ERR2 SHALL be processed back-to-back with no idle cycle.
REQ-013 Writes SHALL capture HWDATA at the DONE edge with byte enables:
 - byte: lane HADDR[1:0];
 - halfword: lanes HADDR[1]*2 and HADDR[1]*2+1;
 - word: all four lanes.
REQ-014 Reads SHALL drive HRDATA with the full word during DONE; HRDATA SHALL hold its last value otherwise.
REQ-015 Split handling:
 - on the SPLIT response, record the master ID and load an 8-bit counter with SPLIT_DLY;
 - the counter decrements every cycle;
 - at 0, drive HSPLIT[ID]=1 for exactly one cycle, then clear the pending flag;
 - the retried access from that master SHALL then receive OKAY.
REQ-016 While a split is pending, accesses from other masters SHALL be served normally (OKAY or ERROR) without disturbing the counter.
REQ-017 Only one split SHALL be pending at a time; a master ID >= NUM_MST SHALL never be split and is served OKAY.

Reset
REQ-018 While HRST=1 the outputs SHALL be HREADY_O=1, HRESP=OKAY, HRDATA=0 and HSPLIT=0; the FSM SHALL be in IDLE and the split flag and counters cleared.
REQ-019 Reset asserted mid-transfer SHALL abort that transfer immediately and leave no partial write committed.
REQ-020 Storage contents SHALL NOT be reset.

Structure
REQ-021 HTRANS codes, HRESP codes, HSIZE codes and the FSM state encoding SHALL be defined in the shared package ahb_pkg, which also serves the master, arbiter and decoder.
REQ-022 The storage SHALL be the sub-module ahb_ram_bytes: MEM_DEPTH x 32 with a per-byte write enable and asynchronous read.

Verification
REQ-023 The bench SHALL cover these scenarios:
 - WAIT_CYC=2, word write 0xDEADBEEF to 0x10, then a read of 0x10: HREADY_O low for 2 cycles on each transfer, and HRDATA=0xDEADBEEF in the read's DONE cycle.
 - Byte write 0xAA to 0x13 over the existing 0xDEADBEEF, then a word read: HRDATA=0xAAADBEEF.
 - Read of 0x100 with MEM_DEPTH=64: HREADY_O=0 with HRESP=ERROR, then HREADY_O=1 with HRESP=ERROR, then OKAY; misaligned word 0x02 gives the same two-cycle ERROR.
 - SPLIT_EN=1, master 1 reads 0x04 with SPLIT_DLY=8: two-cycle SPLIT, HSPLIT=0x0002 for one cycle 8 cycles later, and the retry returns OKAY with data.
 - Split pending for master 1 while master 2 writes 0x08: master 2 completes OKAY, and the HSPLIT timing for master 1 is unchanged.
 - HRST pulsed during the WAIT state of a write: outputs return to reset values asynchronously, and a following read shows the old word.
